// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 4:1 demux/selector.
package demux_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_IN0   = 2'd0;
   localparam sel_t SEL_IN1   = 2'd1;
   localparam sel_t SEL_IN2   = 2'd2;
   localparam sel_t SEL_IN3   = 2'd3;
   localparam int   SEL_DEC_W = 4;

endpackage

// File: rtl/demux_sel_decode.sv
// Combinational 2-to-4 one-hot decoder for the select index.
// Only compiled in when DEMUX_SEL_DECODE_EN is defined.
`ifdef DEMUX_SEL_DECODE_EN
module demux_sel_decode
   import demux_pkg::*;
(
   input  sel_t                 sel,
   output logic [SEL_DEC_W-1:0] dec
);

   always_comb begin
      dec      = '0;
      dec[sel] = 1'b1;
   end

endmodule
`endif

// File: rtl/demux.sv
// Registered 4-input selector: captures in[sel] and sel on en, flags out_valid.
// DEMUX_SEL_DECODE_EN adds a registered one-hot sel_dec output.
module demux
   import demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [WIDTH-1:0]     in0,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   input  logic [WIDTH-1:0]     in3,
   input  logic                 d0,
   input  logic                 d1,
   output logic [WIDTH-1:0]     out,
   output logic                 out_valid,
   output sel_t                 sel_q
`ifdef DEMUX_SEL_DECODE_EN
   ,
   output logic [SEL_DEC_W-1:0] sel_dec
`endif
);

   sel_t             sel;
   sel_t             sel_d;
   logic [WIDTH-1:0] out_mux;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;
   logic             out_valid_d;
   logic             out_valid_q;

   always_comb begin
      sel     = {d1, d0};
      out_mux = '0;
      unique case (sel)
         SEL_IN0: out_mux = in0;
         SEL_IN1: out_mux = in1;
         SEL_IN2: out_mux = in2;
         SEL_IN3: out_mux = in3;
         default: out_mux = '0;
      endcase
   end

   always_comb begin
      out_d       = out_q;
      sel_d       = sel_q;
      out_valid_d = en;
      if (en) begin
         out_d = out_mux;
         sel_d = sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         sel_q       <= SEL_IN0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

`ifdef DEMUX_SEL_DECODE_EN
   logic [SEL_DEC_W-1:0] dec_w;
   logic [SEL_DEC_W-1:0] sel_dec_d;
   logic [SEL_DEC_W-1:0] sel_dec_q;

   demux_sel_decode u_sel_decode (
      .sel (sel),
      .dec (dec_w)
   );

   always_comb begin
      sel_dec_d = sel_dec_q;
      if (en) sel_dec_d = dec_w;
   end

   always_ff @(posedge clk) begin
      if (reset) sel_dec_q <= '0;
      else       sel_dec_q <= sel_dec_d;
   end

   assign sel_dec = sel_dec_q;
`endif

   // An unknown select on a capture edge is a don't-care in hardware but a bug upstream.
   a_sel_known : assert property (@(posedge clk) disable iff (reset)
                                  en |-> !$isunknown({d1, d0}));

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed scenarios plus randomized steps
// compared against an index-the-array reference model.
module tb_demux;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, en, d0, d1;
   logic [W-1:0] in0, in1, in2, in3;
   logic [W-1:0] out;
   logic         out_valid;
   logic [1:0]   sel_q;
`ifdef DEMUX_SEL_DECODE_EN
   logic [3:0]   sel_dec;
`endif

   int passed = 0;
   int total  = 0;
   int failed = 0;

   logic [W-1:0] m_out;
   logic [1:0]   m_sel;
   logic         m_valid;

   always #5 clk = ~clk;

   demux #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .d0        (d0),
      .d1        (d1),
      .out       (out),
      .out_valid (out_valid),
      .sel_q     (sel_q)
`ifdef DEMUX_SEL_DECODE_EN
      ,
      .sel_dec   (sel_dec)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic e, input logic [1:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
      logic [W-1:0] src [4];
      @(negedge clk);
      reset = r; en = e; {d1, d0} = s;
      in0 = a; in1 = b; in2 = c; in3 = d;
      src = '{a, b, c, d};
      @(posedge clk);
      if (r) begin
         m_out = '0; m_sel = 2'd0; m_valid = 1'b0;
      end else begin
         m_valid = e;
         if (e) begin
            m_out = src[s];
            m_sel = s;
         end
      end
      #1;
      chk({tag, ".out"},       64'(out),       64'(m_out));
      chk({tag, ".sel_q"},     64'(sel_q),     64'(m_sel));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
`ifdef DEMUX_SEL_DECODE_EN
      chk({tag, ".sel_dec"},   64'(sel_dec),   r ? 64'd0 : 64'(4'b0001 << m_sel));
`endif
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; d0 = 1'b0; d1 = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      m_out = '0; m_sel = '0; m_valid = 1'b0;

      step("rst0", 1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      step("rst1", 1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);

      for (int s = 0; s < 4; s++)
         step("sweep_in0z", 0, 1, 2'(s), 8'h00, 8'h01, 8'h01, 8'h01);

      for (int z = 1; z < 4; z++) begin
         logic [W-1:0] v [4];
         for (int k = 0; k < 4; k++) v[k] = (k == z) ? 8'h00 : 8'h01;
         for (int s = 0; s < 4; s++)
            step("rotate_zero", 0, 1, 2'(s), v[0], v[1], v[2], v[3]);
      end

      step("hold_cap", 0, 1, 2'd2, 8'h00, 8'h00, 8'h01, 8'h00);
      step("hold_en0", 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      step("hold_en0b", 0, 0, 2'd1, 8'h33, 8'h44, 8'h55, 8'h66);

      step("rst_dom", 1, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h01);
      step("post_rst", 0, 1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h01);

      for (int s = 0; s < 4; s++)
         step("w8_sweep", 0, 1, 2'(s), 8'h00, 8'h5A, 8'hA5, 8'hFF);

      for (int i = 0; i < 300; i++)
         step("rand", ($urandom_range(15) == 0), $urandom_range(1) == 1,
              2'($urandom_range(3)), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter WIDTH, default 1, is the bit width of each data input and of out; legal range 1..64.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 en  input  1  capture strobe; a new selection is sampled only when high.
REQ-006 in0  input  WIDTH  data source for select 0.
REQ-007 in1  input  WIDTH  data source for select 1.
REQ-008 in2  input  WIDTH  data source for select 2.
REQ-009 in3  input  WIDTH  data source for select 3.
REQ-010 d0  input  1  select bit, LSB.
REQ-011 d1  input  1  select bit, MSB.
REQ-012 out  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  high for the cycle after a capture.
REQ-014 sel_q  output  2  registered copy of {d1,d0} from the last capture.

Function
REQ-015 Selection index SHALL be sel = {d1,d0}: 0 -> in0, 1 -> in1, 2 -> in2, 3 -> in3.
REQ-016 On a rising clk edge with reset=0 and en=1, out SHALL load the input chosen by sel and sel_q SHALL load sel; latency is exactly 1 cycle.
REQ-017 With reset=0 and en=0, out and sel_q SHALL hold their values.
REQ-018 out_valid SHALL equal en registered by one cycle: 1 after a capture edge, 0 after a non-capture edge.
REQ-019 Input data and select changing in the same cycle SHALL be captured together, with no mixing of old and new values.
REQ-020 Back-to-back captures (en held high) SHALL update out every cycle, with no bubble.
REQ-021 Any X on d0/d1 during a capture SHALL be treated as don't-care for synthesis; simulation assertions SHALL flag it.
REQ-022 There is no combinational path from any input to any output.

Reset
REQ-023 On a rising clk edge with reset=1: out=0, sel_q=0, out_valid=0 (and sel_dec=0 when compiled in).
REQ-024 Reset SHALL dominate en; asserting reset in the middle of a capture stream discards that cycle's capture.
REQ-025 The first capture is possible on the first edge after reset is deasserted.

Configuration
REQ-026 Macro DEMUX_SEL_DECODE_EN: when defined, adds output sel_dec (output, 4 bits), a registered one-hot decode of sel, updated under the same en/reset rules as sel_q (sel 0 -> 0001, 1 -> 0010, 2 -> 0100, 3 -> 1000; reset -> 0000).
REQ-027 Without DEMUX_SEL_DECODE_EN, the sel_dec port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-028 Shared package demux_pkg SHALL hold the typedef sel_t (2 bits), the constants SEL_IN0..SEL_IN3 (0..3), and the constant SEL_DEC_W=4.
REQ-029 One sub-module, demux_sel_decode (a combinational 2-to-4 one-hot decoder), SHALL be instantiated only under DEMUX_SEL_DECODE_EN.
REQ-030 All outputs SHALL be driven directly from flops in demux.

Verification
REQ-031 Scenario: reset=1 for 2 cycles -> out=0, sel_q=0, out_valid=0, sel_dec=0000.
REQ-032 Scenario: in0=0, in1=1, in2=1, in3=1, en=1, {d1,d0} stepping 00,01,10,11, one step per cycle -> out is 0,1,1,1 one cycle later; out_valid=1 throughout.
REQ-033 Scenario: rotate the single 0 through in1, then in2, then in3, repeating the four-step select sweep each time -> out=0 only when sel equals the index of the zero input; sel_dec tracks 0001,0010,0100,1000.
REQ-034 Scenario: capture sel=10 with in2=1, then en=0 with sel=00 and in2=0 -> out stays 1, sel_q stays 10, out_valid=0.
REQ-035 Scenario: en=1 with reset=1 in the same cycle, in3=1, sel=11 -> out=0, out_valid=0; next edge with reset=0 -> out=1.
REQ-036 Scenario: WIDTH=8 with in0=0x00, in1=0x5A, in2=0xA5, in3=0xFF, sweeping sel -> out follows 0x00, 0x5A, 0xA5, 0xFF at 1-cycle latency.
